// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input sync, mid-bit sampling and framing-error strobe.
// Optional UART_RX_MAJORITY_EN: every sample point uses the 2-of-3 majority of the last three rx_s values.
module uart_rx #(
  parameter int clkfreq  = 100_000_000,
  parameter int baudrate = 115_200,
  parameter int stopbit  = 2
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] dout_o,
  output logic       rx_done_o,
  output logic       frame_err_o,
  output logic       busy_o
);
  localparam int unsigned T = clkfreq / baudrate;
  localparam int unsigned H = T / 2;

  if (clkfreq / baudrate < 4 || stopbit < 1) begin : g_bad_cfg
    $error("uart_rx: clkfreq/baudrate must be >= 4 and stopbit >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [31:0] bittimer_q, bittimer_d;
  logic [2:0]  bitcntr_q, bitcntr_d;
  logic [7:0]  shift_q, shift_d, dout_d;
  logic        armed_q, armed_d;
  logic        done_d, ferr_d;
  logic [1:0]  sync_q;
  logic        rx_s, samp;

  always_ff @(posedge clk) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rx_i};
  end
  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rx_s one edge back, hist_q[1] two edges back
  logic [1:0] hist_q;
  always_ff @(posedge clk) begin
    if (!rst_ni) hist_q <= 2'b11;
    else         hist_q <= {hist_q[0], rx_s};
  end
  assign samp = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign samp = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      bittimer_q  <= '0;
      bitcntr_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      dout_o      <= '0;
      rx_done_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      bittimer_q  <= bittimer_d;
      bitcntr_q   <= bitcntr_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      dout_o      <= dout_d;
      rx_done_o   <= done_d;
      frame_err_o <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bittimer_d = bittimer_q;
    bitcntr_d  = bitcntr_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    dout_d     = dout_o;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bittimer_d = '0;
        bitcntr_d  = '0;
        // a line held low after a break or bad frame must go high before re-arming
        if (rx_s) armed_d = 1'b1;
        else if (armed_q) begin
          armed_d = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bittimer_q == 32'(H - 1)) begin
          bittimer_d = '0;
          state_d    = samp ? S_IDLE : S_DATA;
        end else bittimer_d = bittimer_q + 32'd1;
      end
      S_DATA: begin
        if (bittimer_q == 32'(T - 1)) begin
          bittimer_d = '0;
          shift_d    = {samp, shift_q[7:1]};
          bitcntr_d  = bitcntr_q + 3'd1;
          if (bitcntr_q == 3'd7) state_d = S_STOP;
        end else bittimer_d = bittimer_q + 32'd1;
      end
      S_STOP: begin
        if (bittimer_q == 32'(T - 1)) begin
          bittimer_d = '0;
          state_d    = S_IDLE;
          if (samp) begin
            dout_d = shift_q;
            done_d = 1'b1;
          end else ferr_d = 1'b1;
        end else bittimer_d = bittimer_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + random line waveforms checked cycle by cycle against a frame-level decoder model.
module tb_uart_rx;
  localparam int T    = 16;
  localparam int H    = 8;
  localparam int MAXN = 20000;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] dout_o;
  logic       rx_done_o, frame_err_o, busy_o;

  uart_rx #(.clkfreq(16), .baudrate(1), .stopbit(2)) dut (
    .clk(clk), .rst_ni(rst_ni), .rx_i(rx_i), .dout_o(dout_o),
    .rx_done_o(rx_done_o), .frame_err_o(frame_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // line_a/rst_a: values driven during cycle n (after edge n); obs_a/exp_a: outputs after edge n
  bit          line_a [MAXN];
  bit          rst_a  [MAXN];
  bit          rs_a   [MAXN];
  logic [10:0] obs_a  [MAXN];
  logic [10:0] exp_a  [MAXN];
  int          n_len = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      line_a[n_len] = v;
      rst_a[n_len]  = 1'b1;
      n_len++;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop_v);
    put(1'b0, T);
    for (int k = 0; k < 8; k++) put(b[k], T);
    put(stop_v, T);
  endtask

  function automatic bit is_rst(input int e);
    return (e == 0) || (rst_a[e-1] == 1'b0);
  endfunction

  function automatic bit rsv(input int e);
    return (e >= 0 && e < n_len) ? rs_a[e] : 1'b1;
  endfunction

  function automatic bit smp(input int e);
`ifdef UART_RX_MAJORITY_EN
    bit a, b, c;
    a = rsv(e); b = rsv(e - 1); c = rsv(e - 2);
    return (a & b) | (a & c) | (b & c);
`else
    return rsv(e);
`endif
  endfunction

  function automatic void setx(input int e, input bit bsy, input bit dn, input bit fe, input logic [7:0] d);
    if (e < n_len) exp_a[e] = {bsy, dn, fe, d};
  endfunction

  // Frame-level decoder: find a start (armed rule), look up sample points by timing formula
  task automatic build_model();
    int r, e, fin, ab;
    bit armed, ok;
    logic [7:0] dv, byt;
    r = 0;
    for (int i = 0; i < n_len; i++) begin
      if (is_rst(i)) r = i;
      rs_a[i] = (i - 3 >= r) ? line_a[i-3] : 1'b1;
    end
    armed = 1'b0; dv = 8'h00; e = 0;
    while (e < n_len) begin
      if (is_rst(e)) begin
        armed = 1'b0; dv = 8'h00; setx(e, 0, 0, 0, dv); e++;
      end else if (!armed || rs_a[e]) begin
        if (rs_a[e]) armed = 1'b1;
        setx(e, 0, 0, 0, dv); e++;
      end else begin
        armed = 1'b0;
        ok  = (smp(e + H) == 1'b0);
        fin = ok ? e + H + 9*T : e + H;
        ab  = -1;
        for (int x = e + 1; x <= fin && x < n_len; x++)
          if (ab < 0 && is_rst(x)) ab = x;
        if (ab >= 0) begin
          for (int x = e; x < ab; x++) setx(x, 1, 0, 0, dv);
          e = ab;
        end else begin
          for (int k = 0; k < 8; k++) byt[k] = smp(e + H + (k + 1)*T);
          for (int x = e; x < fin; x++) setx(x, 1, 0, 0, dv);
          if (!ok) setx(fin, 0, 0, 0, dv);
          else if (smp(fin)) begin dv = byt; setx(fin, 0, 1, 0, dv); end
          else setx(fin, 0, 0, 1, dv);
          e = fin + 1;
        end
      end
    end
  endtask

  function automatic int cnt(input int bitpos, input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i < hi; i++) if (obs_a[i][bitpos]) c++;
    return c;
  endfunction

  int s_a5, s_b2b, s_fe, s_gl, s_rs, r_rs, s_96, s_0f, kind, off, s;
  logic [7:0] rb, exp0f;

  initial begin
    // directed section
    put(1'b1, 20);
    s_a5 = n_len;  send(8'hA5, 1'b1); put(1'b1, T + 10);
    s_b2b = n_len; send(8'h00, 1'b1); send(8'hFF, 1'b1); put(1'b1, 20);
    s_fe = n_len;  send(8'h3C, 1'b0); put(1'b0, 64); put(1'b1, 20);
    s_gl = n_len;  put(1'b0, 3); put(1'b1, 30);
    s_rs = n_len;  put(1'b0, T);
    for (int k = 0; k < 4; k++) put(k[0] ? 1'b1 : 1'b0, T);  // 0x5A low nibble: 0,1,0,1
    r_rs = n_len;  put(1'b1, 20); rst_a[r_rs] = 1'b0;
    s_96 = n_len;  send(8'h96, 1'b1); put(1'b1, T + 10);
    s_0f = n_len;  send(8'h0F, 1'b1); put(1'b1, 20);
    line_a[s_0f + H + 4*T] = ~line_a[s_0f + H + 4*T];
    // random section
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      rb   = 8'($urandom);
      if (kind < 5) begin
        send(rb, 1'b1); put(1'b1, $urandom_range(0, 1) * T + $urandom_range(0, 20));
      end else if (kind < 7) begin
        send(rb, 1'b0); put(1'b0, $urandom_range(0, 40)); put(1'b1, $urandom_range(1, 20));
      end else if (kind < 9) begin
        put(1'b0, $urandom_range(1, 6)); put(1'b1, $urandom_range(3, 20));
      end else begin
        off = $urandom_range(1, 9*T);
        s = n_len; send(rb, 1'b1); n_len = s + off;
        s = n_len; put(1'b1, 20); rst_a[s] = 1'b0;
      end
    end
    put(1'b1, 40);
    rst_a[0] = 1'b0;

    for (int n = 0; n < n_len; n++) begin
      @(posedge clk); #1;
      obs_a[n] = {busy_o, rx_done_o, frame_err_o, dout_o};
      rx_i   = line_a[n];
      rst_ni = rst_a[n];
    end

    build_model();
    for (int n = 0; n < n_len; n++)
      chk($sformatf("cyc%0d", n), 32'(obs_a[n]), 32'(exp_a[n]));

    chk("rst_state", 32'(obs_a[1]), 32'h0);
    chk("a5_done",   32'(obs_a[s_a5 + 155][9]), 32'd1);
    chk("a5_dout",   32'(obs_a[s_a5 + 155][7:0]), 32'hA5);
    chk("a5_early",  32'(obs_a[s_a5 + 154][9]), 32'd0);
    chk("a5_width",  32'(obs_a[s_a5 + 156][9]), 32'd0);
    chk("a5_ferr",   32'(cnt(8, s_a5, s_b2b)), 32'd0);
    chk("b2b_d0",    32'(obs_a[s_b2b + 155]), 32'h200);
    chk("b2b_d1",    32'(obs_a[s_b2b + 315]), 32'h2FF);
    chk("b2b_cnt",   32'(cnt(9, s_b2b, s_fe)), 32'd2);
    chk("fe_cnt",    32'(cnt(8, s_fe, s_gl)), 32'd1);
    chk("fe_nodone", 32'(cnt(9, s_fe, s_gl)), 32'd0);
    chk("fe_dout",   32'(obs_a[s_gl - 1][7:0]), 32'hFF);
    chk("gl_busy",   32'(cnt(10, s_gl, s_rs)), 32'd8);
    chk("gl_strobe", 32'(cnt(9, s_gl, s_rs) + cnt(8, s_gl, s_rs)), 32'd0);
    chk("rs_busy",   32'(obs_a[r_rs][10]), 32'd1);
    chk("rs_after",  32'(obs_a[r_rs + 1]), 32'h0);
    chk("96_done",   32'(obs_a[s_96 + 155]), 32'h296);
`ifdef UART_RX_MAJORITY_EN
    exp0f = 8'h0F;
`else
    exp0f = 8'h07;
`endif
    chk("0f_dout",   32'(obs_a[s_0f + 155]), {21'd0, 3'b010, exp0f});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

- Asynchronous serial receiver: 8 data bits, LSB first, no parity.
- Samples a 2-flop-synchronised line at mid-bit and reassembles the byte.
- Reports each received byte with a one-cycle strobe; flags framing errors.
- Pairs with the team's UART transmitter: same parameters, same bit timing. Sits between the board RX pin and the byte-level command logic.

## Interface
- clkfreq, 100_000_000: clock frequency in Hz.
- baudrate, 115_200: line rate in bit/s. T = clkfreq / baudrate clocks per bit (integer division); H = T / 2.
- stopbit, 2: stop bits sent by the far end. The receiver checks only the first one (see Operation).
- clk  input  1  system clock; all logic is on the rising edge.
- rst_ni  input  1  reset; one clock, reset is synchronous and active-low.
- rx_i  input  1  serial line, asynchronous to clk; idle high.
- dout_o  output  8  last good byte; held until the next good byte.
- rx_done_o  output  1  one-cycle strobe: dout_o was just updated.
- frame_err_o  output  1  one-cycle strobe: stop bit sampled low.
- busy_o  output  1  high while a frame is in progress (any state other than S_IDLE).

## Operation
- Synchronisation:
  - rx_i passes through two flops to give rx_s.
  - Both flops reset to 1.
  - All decisions use rx_s only.
- Counters:
  - bittimer is 32 bits and counts 0..T-1.
  - bitcntr is 3 bits.
- State machine states: S_IDLE, S_START, S_DATA, S_STOP.
- S_IDLE:
  - bittimer = 0, bitcntr = 0.
  - armed flag is set while rx_s = 1.
  - If armed and rx_s = 0: go to S_START and clear armed.
  - The armed flag prevents a held-low line (break, or the tail of a framing error) from retriggering.
- S_START:
  - Count to H-1, then re-sample.
  - rx_s = 0: valid start; bittimer <= 0, go to S_DATA.
  - rx_s = 1: glitch; return to S_IDLE with no strobe.
- S_DATA:
  - Each time bittimer reaches T-1, sample rx_s into shift_reg[7] and shift right (so bit 0 ends up in [0]).
  - bittimer <= 0, bitcntr++.
  - After the 8th sample (bitcntr was 7): bitcntr <= 0, go to S_STOP.
- S_STOP:
  - At bittimer = T-1, sample the stop bit.
  - Stop bit = 1: dout_o <= shift_reg, pulse rx_done_o.
  - Stop bit = 0: pulse frame_err_o; dout_o is unchanged.
  - Either way, go to S_IDLE.
  - Extra stop bits are absorbed as idle line, which also allows back-to-back frames with stopbit = 1.
- Reset (rst_ni = 0 at a clock edge), including mid-frame:
  - state = S_IDLE, counters = 0, shift_reg = 0, armed = 0.
  - All outputs go to their reset values; no strobe is emitted for the aborted frame.
- Output reset values: dout_o = 0x00, rx_done_o = 0, frame_err_o = 0, busy_o = 0.

## Timing
- Let t0 be the first clock edge at which rx_s = 0 in S_IDLE while armed.
  - Start re-check: edge t0+H.
  - Data bit k (k = 0..7): sampled at edge t0+H+(k+1)·T.
  - Stop bit: sampled at edge t0+H+9·T.
- Strobes:
  - rx_done_o / frame_err_o are high for exactly the one cycle after the stop-sample edge.
  - dout_o changes on that same edge.
- Latency from the rx_i falling edge to rx_done_o: 2 (synchroniser) + H + 9·T + 1 clocks, ±1 clock for the asynchronous phase of rx_i.
- busy_o:
  - Rises the cycle after t0.
  - Falls the same cycle the strobe rises.
- Ready for the next start bit: the first cycle after a strobe, provided rx_s = 1 at some point (the armed rule).
- T must be ≥ 4; smaller values are unsupported.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Every sample point (start re-check, data, stop) uses the 2-of-3 majority of rx_s at the sample edge and the two preceding edges.
  - Sample timing is unchanged.
  - A single-cycle glitch adjacent to a sample point is rejected.
- Undefined: a single sample of rx_s at the sample edge.

## Test plan
- Params clkfreq=16, baudrate=1 (T=16, H=8). Send 0xA5 with 2 stop bits -> dout_o=0xA5 and rx_done_o high for 1 cycle at t0+8+144+1; frame_err_o stays 0.
- Send 0x00 then 0xFF back-to-back with stopbit=1 -> two rx_done_o pulses exactly 160 clocks apart; dout_o = 0x00, then 0xFF.
- Send 0x3C with the stop bit driven low, then hold the line low for 64 clocks -> frame_err_o pulses once; dout_o keeps its previous value; no second frame starts until rx_i returns high.
- Drive rx_i low for 3 clocks from idle -> returns to S_IDLE at t0+8; busy_o high for 8 cycles; no strobes.
- Assert rst_ni low for 1 cycle after 4 data bits of 0x5A -> all outputs at reset values the next cycle; a following full 0x96 frame is received correctly.
- With UART_RX_MAJORITY_EN: invert rx_i for 1 clock exactly at the bit-3 sample point of 0x0F -> dout_o = 0x0F (without the macro, dout_o = 0x07).
